// File: rtl/fetch_queue.sv
// fetch_queue: PC generator plus DEPTH-entry instruction queue between a 1-cycle imem and decode
module fetch_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic [ADDR_WIDTH-1:0]        imem_addr,
    output logic                         imem_req,
    input  logic                         imem_ready,
    input  logic [DATA_WIDTH-1:0]        imem_data,
    input  logic                         redirect,
    input  logic [ADDR_WIDTH-1:0]        redirect_pc,
    output logic                         inst_valid,
    output logic [DATA_WIDTH-1:0]        inst,
    output logic [ADDR_WIDTH-1:0]        inst_pc,
    input  logic                         inst_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = CW + 1;
    localparam int PW = $clog2(DEPTH);
    logic [ADDR_WIDTH-1:0] pc, inflight_pc;
    logic inflight, pop, accept, unused;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [DATA_WIDTH-1:0] q_inst [DEPTH];
    logic [ADDR_WIDTH-1:0] q_pc [DEPTH];
    assign unused = ^redirect_pc[1:0];
    assign imem_addr = pc;
    assign inst_valid = count != '0;
    assign pop = inst_valid && inst_ready;
    assign inst = inst_valid ? q_inst[rd_ptr] : '0;
    assign inst_pc = inst_valid ? q_pc[rd_ptr] : '0;
    // only request when the response is guaranteed a free slot on arrival
    assign imem_req = !reset && !redirect &&
                      (({1'b0, count} + SW'(inflight) - SW'(pop)) < SW'(DEPTH));
    assign accept = imem_req && imem_ready;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
            inflight <= 1'b0;
            inflight_pc <= '0;
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_inst[i] <= '0;
                q_pc[i] <= '0;
            end
        end else if (redirect) begin
            pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            inflight <= 1'b0;
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            inflight <= accept;
            if (accept) begin
                pc <= pc + ADDR_WIDTH'(4);
                inflight_pc <= pc;
            end
            if (inflight) begin
                q_inst[wr_ptr] <= imem_data;
                q_pc[wr_ptr] <= inflight_pc;
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(inflight) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue with a 1-cycle imem model returning addr ^ 32'hA5A5_0000
module tb_fetch_queue;
    localparam logic [31:0] K = 32'hA5A5_0000;
    logic clock = 1'b0, reset = 1'b1;
    logic [31:0] imem_addr, imem_data, redirect_pc, inst, inst_pc;
    logic imem_req, imem_ready = 1'b1, redirect = 1'b0, inst_valid, inst_ready = 1'b1;
    logic [2:0] count;
    int n_checks = 0, n_fail = 0;

    fetch_queue dut (
        .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_ready(imem_ready), .imem_data(imem_data), .redirect(redirect),
        .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .inst_ready(inst_ready), .count(count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) imem_data <= imem_addr ^ K;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_valid", 32'(inst_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_req", 32'(imem_req), 0);
        check("rst_addr", imem_addr, 0);
        check("rst_inst", inst, 0);
        check("rst_pc", inst_pc, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        redirect_pc = '0;
        // sequential fetch after reset
        do_reset();
        for (int k = 0; k < 8; k++) begin
            check("seq_addr", imem_addr, 32'(4 * k));
            check("seq_req", 32'(imem_req), 1);
            if (k >= 2) begin
                check("seq_valid", 32'(inst_valid), 1);
                check("seq_pc", inst_pc, 32'(4 * (k - 2)));
                check("seq_inst", inst, 32'(4 * (k - 2)) ^ K);
            end else
                check("seq_nvalid", 32'(inst_valid), 0);
            tick();
        end
        // back-to-back redirects during push+pop; the last one wins
        redirect = 1'b1;
        redirect_pc = 32'h200;
        #1;
        check("rd_req0", 32'(imem_req), 0);
        tick();
        redirect_pc = 32'h43;
        #1;
        check("rd_req1", 32'(imem_req), 0);
        check("rd_cnt1", 32'(count), 0);
        tick();
        redirect = 1'b0;
        #1;
        check("rd_cnt", 32'(count), 0);
        check("rd_valid", 32'(inst_valid), 0);
        check("rd_addr", imem_addr, 32'h40);
        check("rd_req", 32'(imem_req), 1);
        tick();
        check("rd_stale", 32'(inst_valid), 0);
        tick();
        check("rd_pc", inst_pc, 32'h40);
        check("rd_inst", inst, 32'h40 ^ K);
        tick();
        check("rd_pc2", inst_pc, 32'h44);
        // backpressure fills the queue
        inst_ready = 1'b0;
        tick();
        do_reset();
        repeat (4) tick();
        check("bp_cnt3", 32'(count), 3);
        check("bp_req3", 32'(imem_req), 0);
        tick();
        check("bp_cnt4", 32'(count), 4);
        check("bp_req4", 32'(imem_req), 0);
        check("bp_addr", imem_addr, 32'h10);
        tick();
        check("bp_hold", 32'(count), 4);
        inst_ready = 1'b1;
        #1;
        check("bp_rel_req", 32'(imem_req), 1);
        for (int j = 0; j < 5; j++) begin
            check("bp_valid", 32'(inst_valid), 1);
            check("bp_pc", inst_pc, 32'(4 * j));
            check("bp_inst", inst, 32'(4 * j) ^ K);
            tick();
        end
        // redirect with a response in flight and the queue at capacity
        inst_ready = 1'b0;
        do_reset();
        repeat (4) tick();
        check("rf_cnt", 32'(count), 3);
        redirect = 1'b1;
        redirect_pc = 32'h103;
        #1;
        check("rf_req", 32'(imem_req), 0);
        tick();
        redirect = 1'b0;
        inst_ready = 1'b1;
        #1;
        check("rf_cnt0", 32'(count), 0);
        check("rf_valid", 32'(inst_valid), 0);
        check("rf_addr", imem_addr, 32'h100);
        check("rf_req1", 32'(imem_req), 1);
        tick();
        check("rf_stale", 32'(inst_valid), 0);
        tick();
        check("rf_pc", inst_pc, 32'h100);
        check("rf_inst", inst, 32'h100 ^ K);
        tick();
        // memory stall for three cycles
        check("st_pc0", inst_pc, 32'h104);
        check("st_addr0", imem_addr, 32'h10c);
        imem_ready = 1'b0;
        tick();
        check("st_addr1", imem_addr, 32'h10c);
        check("st_pc1", inst_pc, 32'h108);
        tick();
        check("st_addr2", imem_addr, 32'h10c);
        check("st_valid2", 32'(inst_valid), 0);
        tick();
        check("st_addr3", imem_addr, 32'h10c);
        check("st_valid3", 32'(inst_valid), 0);
        imem_ready = 1'b1;
        tick();
        check("st_valid4", 32'(inst_valid), 0);
        check("st_addr4", imem_addr, 32'h110);
        tick();
        check("st_pc5", inst_pc, 32'h10c);
        tick();
        check("st_pc6", inst_pc, 32'h110);
        // asynchronous reset between clock edges, then restart
        #2;
        do_reset();
        check("ar_addr", imem_addr, 0);
        check("ar_req", 32'(imem_req), 1);
        tick();
        tick();
        check("ar_valid", 32'(inst_valid), 1);
        check("ar_pc", inst_pc, 0);
        check("ar_inst", inst, K);
        // push and pop together with two entries held
        inst_ready = 1'b0;
        tick();
        do_reset();
        repeat (3) tick();
        check("pp_cnt", 32'(count), 2);
        inst_ready = 1'b1;
        tick();
        check("pp_cnt1", 32'(count), 2);
        check("pp_pc1", inst_pc, 32'h4);
        tick();
        check("pp_cnt2", 32'(count), 2);
        check("pp_pc2", inst_pc, 32'h8);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the pipelined MIPS core. It replaces the single fetch/decode latch with a PC generator and a DEPTH-entry instruction queue. The queue is filled from a synchronous instruction memory with one-cycle read latency and drained by decode through a valid/ready handshake. Taken branches, jumps and jr enter as a single redirect, which flushes the queue and cancels the in-flight fetch.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of PC and instruction addresses
- DATA_WIDTH, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 0, PC loaded on reset; word aligned

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- imem_addr  out  ADDR_WIDTH  fetch address, equal to the current PC register
- imem_req  out  1  fetch request this cycle
- imem_ready  in  1  memory accepts the request this cycle
- imem_data  in  DATA_WIDTH  instruction, valid in the cycle after an accepted request
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  ADDR_WIDTH  new PC; bits [1:0] ignored and forced to 0
- inst_valid  out  1  queue head valid
- inst  out  DATA_WIDTH  head instruction; 0 when inst_valid is low
- inst_pc  out  ADDR_WIDTH  address of the head instruction; 0 when inst_valid is low
- inst_ready  in  1  decode consumes the head
- count  out  $clog2(DEPTH+1)  queue occupancy

## Operation
- State:
  - pc register
  - inflight flag: a response is due this cycle
  - inflight_pc: address of that response
  - circular buffer of DEPTH {inst, pc} entries, with read pointer, write pointer and count
- Pop: a pop occurs when inst_valid && inst_ready. inst_valid = (count != 0).
- Request: imem_req = !redirect && (count + inflight − pop < DEPTH). This guarantees space for every response, so the queue never overflows and no response is dropped.
- Accept: an accept occurs when imem_req && imem_ready. On accept:
  - pc advances by 4, wrapping modulo 2^ADDR_WIDTH;
  - inflight is set for the next cycle, and inflight_pc captures the current pc.
- No accept: inflight clears.
- Push: when inflight is set, {imem_data, inflight_pc} is written at the write pointer at the clock edge.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Redirect has highest priority. In the redirect cycle:
  - imem_req is low;
  - any due response is discarded and not pushed;
  - any pop is ignored and the queue is flushed (count = 0, pointers = 0);
  - inflight clears;
  - pc is loaded with {redirect_pc[ADDR_WIDTH-1:2], 2'b0}.
  Fetch resumes in the next cycle.
- Multiple consecutive redirect cycles: the last one wins.
- imem_ready low: pc holds and imem_addr holds.
- Reset (asynchronous, including mid-operation):
  - pc = RESET_PC, inflight = 0, count = 0, pointers = 0, all queue entries = 0;
  - outputs: imem_req = 0 while reset is high, imem_addr = RESET_PC, inst_valid = 0, inst = 0, inst_pc = 0, count = 0.
  - A response arriving after reset release from a pre-reset request is ignored.

## Timing
- Request to visibility: a request accepted at edge N is pushed at edge N+1, and inst_valid is high in the cycle after edge N+1. This is 2 cycles.
- First request after reset: imem_req is high in the first cycle after reset release; the first instruction is visible 2 cycles later.
- Throughput: with imem_ready and inst_ready held high, one instruction per cycle is delivered at steady state for any DEPTH ≥ 2.
- Redirect penalty: redirect in cycle R. Request at redirect_pc is in cycle R+1, and its instruction is visible in cycle R+3. No stale instruction appears after edge R.
- Outputs: inst, inst_pc and inst_valid are combinational from registered state only. imem_req depends combinationally on redirect and inst_ready.

## Test plan
- Reset and sequential fetch:
  - Stimulus: RESET_PC = 0, memory returns addr ^ 32'hA5A5_0000, imem_ready = 1, inst_ready = 1.
  - Required: imem_addr sequence 0, 4, 8, …; first inst_valid 2 cycles after release with inst_pc = 0, inst = 32'hA5A5_0000; then one instruction per cycle with no gaps.
- Backpressure, DEPTH = 4:
  - Stimulus: inst_ready = 0.
  - Required: count saturates at 4; imem_req falls when count + inflight = 4; raising inst_ready releases entries 0, 4, 8, 12 in order with no loss or duplication.
- Redirect with an in-flight response and a full queue:
  - Stimulus: redirect = 1, redirect_pc = 32'h0000_0103.
  - Required: count = 0 after the edge; next imem_addr = 32'h100; next inst_pc = 32'h100; no stale instruction delivered.
- Memory stall:
  - Stimulus: imem_ready low for 3 cycles.
  - Required: imem_addr holds; no push for those cycles; the order of delivered instructions is unchanged.
- Simultaneous events:
  - Stimulus 1: redirect together with pop and push in the same cycle. Required: redirect wins and count = 0.
  - Stimulus 2: pop and push with count = 2. Required: count stays 2.
- Asynchronous reset mid-burst:
  - Stimulus: reset asserted between clock edges.
  - Required: inst_valid, count and imem_req are 0 immediately; imem_addr = RESET_PC; normal restart after release.
